// File: rtl/mem_pkg.sv
// Shared types and constants for the 6502 memory-side bus responder.
// Used by mem_bus_responder and its testbench.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } mem_state_e;

    // Bus direction encoding shared with the control unit.
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

    localparam int unsigned WAIT_CNT_W = 4;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    function automatic logic addr_in_rom(input logic [15:0] a, input logic [15:0] base);
        return a >= base;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port synchronous byte RAM: one write port and one registered read port
// sharing a single index.
module mem_byte_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 8'h00;
        end else if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for 6502 bus cycles: wait states, byte RAM access, ready pulse.
// Define MEM_BUSERR_EN to fault unmapped addresses (rdata = 8'hFF, bus_err with ready).
module mem_bus_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] ROM_BASE    = 16'hF000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [15:0]       addr,
    input  logic              read_write,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              ready,
    output logic              busy,
    output logic              bus_err,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [7:0]        init_data
);

    localparam wait_cnt_t WAIT_INIT = wait_cnt_t'(WAIT_STATES);
    localparam wait_cnt_t CNT_ONE   = wait_cnt_t'(1);

    mem_state_e        state_q;
    wait_cnt_t         cnt_q;
    logic [15:0]       addr_q;
    logic              rw_q;
    logic [7:0]        wdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              bus_err_q;
    logic              unmapped_rd_q;

    logic [ADDR_W-1:0] cpu_idx;
    logic              rom_hit;
    logic              unmapped;
    logic              init_wr;
    logic              cpu_wr;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_idx;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // Addresses beyond the RAM depth mirror onto the low index bits.
    assign cpu_idx = addr_q[ADDR_W-1:0];
    assign rom_hit = addr_in_rom(addr_q, ROM_BASE);

`ifdef MEM_BUSERR_EN
    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);
    assign unmapped = ({1'b0, addr_q} >= DEPTH) && !rom_hit;
`else
    assign unmapped = 1'b0;
`endif

    // Boot-load only while idle and only when no CPU request competes.
    assign init_wr   = (state_q == StIdle) && !req && init_we;
    assign cpu_wr    = (state_q == StAccess) && (rw_q == WRITE) && !rom_hit && !unmapped;
    assign ram_we    = init_wr || cpu_wr;
    assign ram_re    = (state_q == StAccess) && (rw_q == READ) && !unmapped;
    assign ram_idx   = (state_q == StIdle) ? init_addr : cpu_idx;
    assign ram_wdata = (state_q == StIdle) ? init_data : wdata_q;

    mem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_q        <= '0;
            rw_q          <= READ;
            wdata_q       <= '0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            bus_err_q     <= 1'b0;
            unmapped_rd_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr;
                        rw_q    <= read_write;
                        wdata_q <= wdata;
                        cnt_q   <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    // Only reads update what rdata presents; writes leave it alone.
                    if (rw_q == READ) begin
                        unmapped_rd_q <= unmapped;
                    end
                    ready_q   <= 1'b1;
                    bus_err_q <= unmapped;
                    state_q   <= StResp;
                end
                StResp: begin
                    ready_q   <= 1'b0;
                    bus_err_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rdata   = unmapped_rd_q ? UNMAPPED_DATA : ram_rdata;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed scoreboard bench for mem_bus_responder with WAIT_STATES of 1, 0 and 3.
module tb_mem_bus_responder;
    import mem_pkg::*;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [15:0]   addr;
    logic          read_write;
    logic [7:0]    wdata;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [7:0]    init_data;

    logic [7:0] rdata_v   [3];
    logic       ready_v   [3];
    logic       busy_v    [3];
    logic       bus_err_v [3];

    int total = 0;
    int bad   = 0;
    int pulses   [3] = '{0, 0, 0};
    int accepted [3] = '{0, 0, 0};
    logic [7:0] last_rd [3];

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_bus_responder #(.ADDR_W(AW), .WAIT_STATES(1), .ROM_BASE(16'hF000)) dut_ws1 (
        .clk(clk), .rst(rst), .req(req[0]), .addr(addr), .read_write(read_write),
        .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]),
        .bus_err(bus_err_v[0]), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data)
    );

    mem_bus_responder #(.ADDR_W(AW), .WAIT_STATES(0), .ROM_BASE(16'hF000)) dut_ws0 (
        .clk(clk), .rst(rst), .req(req[1]), .addr(addr), .read_write(read_write),
        .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]),
        .bus_err(bus_err_v[1]), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data)
    );

    mem_bus_responder #(.ADDR_W(AW), .WAIT_STATES(3), .ROM_BASE(16'hF000)) dut_ws3 (
        .clk(clk), .rst(rst), .req(req[2]), .addr(addr), .read_write(read_write),
        .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]),
        .bus_err(bus_err_v[2]), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_v[i] === 1'b1) pulses[i]++;
        end
    end

    function automatic int ws_of(input int inst);
        case (inst)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic init_load(input logic [AW-1:0] idx, input logic [7:0] d);
        init_addr = idx;
        init_data = d;
        init_we   = 1'b1;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    // One bus cycle on instance inst; hold keeps req high through the response cycle.
    task automatic bus_cycle(input int inst, input logic rw, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rd,
                             input logic exp_err, input bit hold, input string tag);
        int   edges;
        bit   seen;
        exp_t e;
        addr       = a;
        read_write = rw;
        wdata      = d;
        req[inst]  = 1'b1;
        accepted[inst]++;
        e.rdata = (rw == WRITE) ? last_rd[inst] : exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        if (rw == READ) last_rd[inst] = exp_rd;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                if (!hold) req[inst] = 1'b0;
                init_we    = 1'b0;
                addr       = 16'($urandom);
                wdata      = 8'($urandom);
                read_write = 1'($urandom);
            end
            if (ready_v[inst] === 1'b1) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(edges), 32'(ws_of(inst) + 2));
        e = sb.pop_front();
        check({tag, "_rdata"}, {24'h0, rdata_v[inst]}, {24'h0, e.rdata});
        check({tag, "_bus_err"}, {31'h0, bus_err_v[inst]}, {31'h0, e.err});
        check({tag, "_busy_resp"}, {31'h0, busy_v[inst]}, 32'h1);
        @(posedge clk);
        #1;
        check({tag, "_ready_drop"}, {31'h0, ready_v[inst]}, 32'h0);
        check({tag, "_idle"}, {31'h0, busy_v[inst]}, 32'h0);
        if (hold) begin
            req[inst] = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check({tag, "_hold_idle"}, {31'h0, busy_v[inst]}, 32'h0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        req        = '0;
        addr       = '0;
        read_write = READ;
        wdata      = '0;
        init_we    = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_rdata", {24'h0, rdata_v[i]}, 32'h0);
            check("rst_ready", {31'h0, ready_v[i]}, 32'h0);
            check("rst_busy", {31'h0, busy_v[i]}, 32'h0);
            check("rst_bus_err", {31'h0, bus_err_v[i]}, 32'h0);
            last_rd[i] = 8'h00;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        init_load(12'h010, 8'hA9);
        init_load(12'h300, 8'h00);
        init_load(12'hFFC, 8'h4C);
        init_load(12'h000, 8'h33);
        init_load(12'h020, 8'h22);

        bus_cycle(0, READ, 16'h0010, 8'h00, 8'hA9, 1'b0, 1'b0, "boot_rd");
        bus_cycle(0, WRITE, 16'h0200, 8'h5C, 8'h00, 1'b0, 1'b0, "wr_0200");
        bus_cycle(0, READ, 16'h0200, 8'h00, 8'h5C, 1'b0, 1'b0, "rd_0200");
`ifdef MEM_BUSERR_EN
        bus_cycle(0, READ, 16'h1200, 8'h00, 8'hFF, 1'b1, 1'b0, "rd_1200");
`else
        bus_cycle(0, READ, 16'h1200, 8'h00, 8'h5C, 1'b0, 1'b0, "rd_mirror");
`endif

        bus_cycle(0, WRITE, 16'hFFFC, 8'h00, 8'h00, 1'b0, 1'b0, "rom_wr");
        bus_cycle(0, READ, 16'hFFFC, 8'h00, 8'h4C, 1'b0, 1'b0, "rom_rd");

        // Boot-load strobe colliding with a request must be dropped.
        init_addr = 12'h020;
        init_data = 8'h11;
        init_we   = 1'b1;
        bus_cycle(0, READ, 16'h0010, 8'h00, 8'hA9, 1'b0, 1'b0, "collide");
        bus_cycle(0, READ, 16'h0020, 8'h00, 8'h22, 1'b0, 1'b0, "collide_rd");

        bus_cycle(1, READ, 16'h0010, 8'h00, 8'hA9, 1'b0, 1'b0, "ws0_rd");
        bus_cycle(2, READ, 16'h0010, 8'h00, 8'hA9, 1'b0, 1'b0, "ws3_rd");
        bus_cycle(1, READ, 16'hFFFC, 8'h00, 8'h4C, 1'b0, 1'b1, "ws0_hold");
        bus_cycle(2, READ, 16'h0300, 8'h00, 8'h00, 1'b0, 1'b1, "ws3_hold");
        bus_cycle(0, READ, 16'h0010, 8'h00, 8'hA9, 1'b0, 1'b1, "ws1_hold");

        // Reset during WAIT aborts the pending write.
        addr       = 16'h0300;
        read_write = WRITE;
        wdata      = 8'h77;
        req[0]     = 1'b1;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        check("abort_busy_wait", {31'h0, busy_v[0]}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy_v[0]}, 32'h0);
        check("abort_ready", {31'h0, ready_v[0]}, 32'h0);
        check("abort_rdata", {24'h0, rdata_v[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        @(posedge clk);
        #1;
        bus_cycle(0, READ, 16'h0300, 8'h00, 8'h00, 1'b0, 1'b0, "abort_rd");

`ifdef MEM_BUSERR_EN
        bus_cycle(0, READ, 16'h2000, 8'h00, 8'hFF, 1'b1, 1'b0, "unm_rd");
        bus_cycle(0, WRITE, 16'h2000, 8'h99, 8'h00, 1'b1, 1'b0, "unm_wr");
        bus_cycle(0, READ, 16'h0000, 8'h00, 8'h33, 1'b0, 1'b0, "unm_chk");
`else
        bus_cycle(0, READ, 16'h2000, 8'h00, 8'h33, 1'b0, 1'b0, "mir_rd");
        bus_cycle(0, WRITE, 16'h2000, 8'h99, 8'h00, 1'b0, 1'b0, "mir_wr");
        bus_cycle(0, READ, 16'h0000, 8'h00, 8'h99, 1'b0, 1'b0, "mir_chk");
`endif

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("ready_pulses", 32'(pulses[i]), 32'(accepted[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the 6502 core's bus cycles.
- Accepts a request strobe with resolved 16-bit address, read/write flag and write data, then inserts programmable wait states.
- Performs the access on an internal byte RAM and returns read data with a one-cycle ready pulse.
- Sits between the datapath address mux and system memory; also provides a boot-load port used by the bench and the loader.

Parameters:
- ADDR_W, 12, RAM index width; RAM depth is 2**ADDR_W bytes.
- WAIT_STATES, 1, idle cycles inserted between request capture and access (0..15).
- ROM_BASE, 16'hF000, CPU writes to addr >= ROM_BASE are discarded; reads are served normally.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  bus cycle request; sampled only in IDLE.
- addr  in  16  CPU byte address.
- read_write  in  1  0 = read, 1 = write.
- wdata  in  8  write data, captured with req.
- rdata  out  8  read data; valid while ready = 1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- bus_err  out  1  access-fault flag, qualified by ready (see Optional Feature).
- init_we  in  1  boot-load write strobe.
- init_addr  in  ADDR_W  boot-load index.
- init_data  in  8  boot-load byte.

Behaviour:
- Reset (asynchronous, rst low):
  - state = IDLE; rdata = 8'h00; ready = 0; busy = 0; bus_err = 0; wait counter = 0.
  - RAM contents are not cleared.
  - Reset mid-cycle aborts the access; a pending write is not performed.
- State IDLE:
  - If req = 1: latch addr, read_write and wdata. Load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else go to ACCESS.
  - Else if init_we = 1: mem[init_addr] <= init_data. ROM protection does not apply.
  - When req and init_we are both high, req wins and init_we is dropped.
- State WAIT: decrement the counter each cycle; go to ACCESS on the cycle the counter reaches 1.
- State ACCESS:
  - Index = latched addr[ADDR_W-1:0]; addresses above the RAM depth mirror.
  - Read: rdata <= mem[index].
  - Write: mem[index] <= wdata, unless latched addr >= ROM_BASE, in which case the write is silently dropped.
  - Next state is RESP.
- State RESP: ready = 1 for exactly this cycle; rdata holds its value; next state is IDLE.
- Latency: req sampled at edge N gives ready high during cycle N + WAIT_STATES + 2.
- rdata holds its value until the next read ACCESS; writes leave rdata unchanged.
- Handshake and input rules:
  - req is ignored while busy; the requester must wait for ready.
  - Back-to-back: req high during the RESP cycle is ignored; it is accepted on the following IDLE cycle.
  - init_we outside IDLE is ignored.
  - addr, read_write and wdata may change freely after capture.

Optional Feature:
- Macro: MEM_BUSERR_EN.
- Enabled:
  - A latched addr with 2**ADDR_W <= addr < ROM_BASE is unmapped.
  - An unmapped read returns rdata = 8'hFF.
  - An unmapped write is dropped.
  - bus_err = 1 alongside ready in RESP.
  - ROM-window addresses index RAM via the low ADDR_W bits, as in the disabled case.
- Disabled: all addresses mirror into RAM; bus_err is tied to 0.

Decomposition:
- Shared package mem_pkg:
  - State encoding IDLE/WAIT/ACCESS/RESP (2 bits).
  - READ = 1'b0, WRITE = 1'b1, matching the control unit's encoding.
  - UNMAPPED_DATA = 8'hFF.
  - Wait-counter width = 4.
- Sub-module mem_byte_ram: single-port synchronous byte array.
  - One write port, muxed between init and CPU writes.
  - One registered read port.
- The FSM and write-protect/decode logic stay in the top level.

Test Plan:
- Boot-load & read: init_we writes 8'hA9 to index 12'h010; then read req at addr 16'h0010 -> ready at cycle +3 (WAIT_STATES = 1), rdata = 8'hA9, bus_err = 0.
- Write then read-back: write 8'h5C to 16'h0200, then read 16'h0200 -> rdata = 8'h5C. A read of mirror address 16'h1200 with the feature off also returns 8'h5C.
- ROM protect: init_we loads 8'h4C at index 12'hFFC; CPU write 8'h00 to 16'hFFFC -> ready pulses; subsequent read of 16'hFFFC -> rdata = 8'h4C.
- Wait states: WAIT_STATES = 0 gives ready at +2; WAIT_STATES = 3 gives ready at +5. req held high while busy causes no extra ready pulses; exactly one ready per accepted req.
- Reset mid-operation: write req to 16'h0300 with data 8'h77, rst low during WAIT -> busy = 0 and ready = 0 immediately; a later read of 16'h0300 returns the prior value (8'h00 after preload).
- MEM_BUSERR_EN defined: read 16'h2000 -> rdata = 8'hFF, bus_err = 1 with ready. Write to 16'h2000 does not alter 16'h0000. Same read with the feature off returns mem[0] and bus_err = 0.
